task3: RTL and testbench

- Board-level top block for a 160x120 VGA framebuffer.
- After reset it clears the whole screen to black, then draws one green circle outline using the midpoint (Bresenham) circle algorithm, and then idles.
- Pixel writes go out on the VGA_X/VGA_Y/VGA_COLOUR/VGA_PLOT bus, which feeds the external VGA adapter.

---
 rtl/task3.sv | 166 ++++++++++++++++
 tb/tb_task3.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/task3.sv
// rtl/task3.sv - clears a 160x120 framebuffer to black, then draws one midpoint circle outline.
// Pixel writes are registered and go out one per clock on the VGA_X/VGA_Y/VGA_COLOUR/VGA_PLOT bus.
module task3 #(
  parameter int CENTRE_X = 80,
  parameter int CENTRE_Y = 60,
  parameter int RADIUS = 40,
  parameter logic [2:0] CIRCLE_COLOUR = 3'b010
) (
  input  logic       CLOCK_50,
  input  logic [3:0] KEY,
  input  logic [9:0] SW,
  output logic [9:0] LEDR,
  output logic [6:0] HEX0,
  output logic [6:0] HEX1,
  output logic [6:0] HEX2,
  output logic [6:0] HEX3,
  output logic [6:0] HEX4,
  output logic [6:0] HEX5,
  output logic [7:0] VGA_R,
  output logic [7:0] VGA_G,
  output logic [7:0] VGA_B,
  output logic       VGA_HS,
  output logic       VGA_VS,
  output logic       VGA_CLK,
  output logic [7:0] VGA_X,
  output logic [6:0] VGA_Y,
  output logic [2:0] VGA_COLOUR,
  output logic       VGA_PLOT
);

  typedef enum logic [2:0] {CLEAR, INIT, OCTANT, UPDATE, DONE} state_t;

  localparam logic signed [10:0] CX = 11'(CENTRE_X);
  localparam logic signed [10:0] CY = 11'(CENTRE_Y);
  localparam logic signed [10:0] RAD = 11'(RADIUS);

  logic clk;
  logic rst;
  logic unused_inputs;

  state_t state, next_state;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] oct;
  logic signed [10:0] ox, oy, crit;
  logic signed [10:0] px, py;
  logic signed [10:0] oy_new, ox_new, crit_new;
  logic in_range;
  logic done_led;

  assign clk = CLOCK_50;
  assign rst = KEY[3];
  assign unused_inputs = ^{KEY[2:0], SW};

  assign LEDR = {9'd0, done_led};
  assign HEX0 = 7'h7F;
  assign HEX1 = 7'h7F;
  assign HEX2 = 7'h7F;
  assign HEX3 = 7'h7F;
  assign HEX4 = 7'h7F;
  assign HEX5 = 7'h7F;
  assign VGA_R = 8'd0;
  assign VGA_G = 8'd0;
  assign VGA_B = 8'd0;
  assign VGA_HS = 1'b0;
  assign VGA_VS = 1'b0;
  assign VGA_CLK = 1'b0;

  always_comb begin
    px = CX;
    py = CY;
    case (oct)
      3'd0: begin px = CX + ox; py = CY + oy; end
      3'd1: begin px = CX + oy; py = CY + ox; end
      3'd2: begin px = CX - ox; py = CY + oy; end
      3'd3: begin px = CX - oy; py = CY + ox; end
      3'd4: begin px = CX - ox; py = CY - oy; end
      3'd5: begin px = CX - oy; py = CY - ox; end
      3'd6: begin px = CX + ox; py = CY - oy; end
      default: begin px = CX + oy; py = CY - ox; end
    endcase
    in_range = (px >= 11'sd0) && (px <= 11'sd159) && (py >= 11'sd0) && (py <= 11'sd119);
  end

  // Midpoint step: the decision term uses the already-updated oy and ox.
  always_comb begin
    oy_new = oy + 11'sd1;
    ox_new = ox;
    crit_new = crit + 11'sd2 * oy_new + 11'sd1;
    if (crit > 11'sd0) begin
      ox_new = ox - 11'sd1;
      crit_new = crit + 11'sd2 * (oy_new - ox_new) + 11'sd1;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      CLEAR:   if (x == 8'd159 && y == 7'd119) next_state = INIT;
      INIT:    next_state = OCTANT;
      OCTANT:  if (oct == 3'd7) next_state = UPDATE;
      UPDATE:  next_state = (oy_new <= ox_new) ? OCTANT : DONE;
      default: next_state = DONE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= CLEAR;
    else     state <= next_state;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x <= 8'd0;
      y <= 7'd0;
      oct <= 3'd0;
      ox <= 11'sd0;
      oy <= 11'sd0;
      crit <= 11'sd0;
      VGA_X <= 8'd0;
      VGA_Y <= 7'd0;
      VGA_COLOUR <= 3'd0;
      VGA_PLOT <= 1'b0;
      done_led <= 1'b0;
    end else begin
      done_led <= (next_state == DONE);
      case (state)
        CLEAR: begin
          VGA_X <= x;
          VGA_Y <= y;
          VGA_COLOUR <= 3'd0;
          VGA_PLOT <= 1'b1;
          if (y == 7'd119) begin
            y <= 7'd0;
            x <= (x == 8'd159) ? 8'd0 : x + 8'd1;
          end else begin
            y <= y + 7'd1;
          end
        end
        INIT: begin
          VGA_PLOT <= 1'b0;
          ox <= RAD;
          oy <= 11'sd0;
          crit <= 11'sd1 - RAD;
          oct <= 3'd0;
        end
        OCTANT: begin
          // Off-screen points still consume their cycle; coordinates are just truncated.
          VGA_X <= px[7:0];
          VGA_Y <= py[6:0];
          VGA_COLOUR <= CIRCLE_COLOUR;
          VGA_PLOT <= in_range;
          oct <= oct + 3'd1;
        end
        UPDATE: begin
          VGA_PLOT <= 1'b0;
          ox <= ox_new;
          oy <= oy_new;
          crit <= crit_new;
        end
        default: VGA_PLOT <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_task3.sv
// tb/tb_task3.sv - directed checks of clear sweep, circle plot order, ring accuracy, clipping and async reset.
module tb_task3;

  logic clk = 1'b0;
  logic [3:0] key = 4'b1000;
  logic [9:0] sw = 10'd0;

  logic [9:0] ledr1, ledr2;
  logic [6:0] h10, h11, h12, h13, h14, h15, h20, h21, h22, h23, h24, h25;
  logic [7:0] r1, g1, b1, r2, g2, b2;
  logic hs1, vs1, vc1, hs2, vs2, vc2;
  logic [7:0] x1, x2;
  logic [6:0] y1, y2;
  logic [2:0] c1, c2;
  logic p1, p2;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  task3 dut (
    .CLOCK_50(clk), .KEY(key), .SW(sw), .LEDR(ledr1),
    .HEX0(h10), .HEX1(h11), .HEX2(h12), .HEX3(h13), .HEX4(h14), .HEX5(h15),
    .VGA_R(r1), .VGA_G(g1), .VGA_B(b1), .VGA_HS(hs1), .VGA_VS(vs1), .VGA_CLK(vc1),
    .VGA_X(x1), .VGA_Y(y1), .VGA_COLOUR(c1), .VGA_PLOT(p1)
  );

  task3 #(.CENTRE_X(5)) dut_edge (
    .CLOCK_50(clk), .KEY(key), .SW(sw), .LEDR(ledr2),
    .HEX0(h20), .HEX1(h21), .HEX2(h22), .HEX3(h23), .HEX4(h24), .HEX5(h25),
    .VGA_R(r2), .VGA_G(g2), .VGA_B(b2), .VGA_HS(hs2), .VGA_VS(vs2), .VGA_CLK(vc2),
    .VGA_X(x2), .VGA_Y(y2), .VGA_COLOUR(c2), .VGA_PLOT(p2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  bit seen_clr [0:159][0:119];
  bit seen_grn [0:159][0:119];
  int exp_ox [0:7] = '{120, 80, 40, 80, 40, 80, 120, 80};
  int exp_oy [0:7] = '{60, 100, 60, 100, 60, 20, 60, 20};
  int sym_x [0:7] = '{120, 81, 40, 79, 40, 79, 120, 81};
  int sym_y [0:7] = '{61, 100, 61, 100, 59, 20, 59, 20};

  int cyc, clr_cnt, clr_uniq, clr_other, grn_cnt, ring_bad, grn2_cnt, clip2_bad;
  int done1, done2, dx, dy, d, sym_ok;

  initial begin
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("reset_plot", p1, 0);
    chk("reset_xy", {x1, y1}, 0);
    chk("reset_colour", c1, 0);
    chk("reset_led", ledr1, 0);
    chk("hex_off", h13, 7'h7F);
    key[3] = 1'b0;

    cyc = 0; clr_cnt = 0; clr_uniq = 0; clr_other = 0;
    grn_cnt = 0; ring_bad = 0; grn2_cnt = 0; clip2_bad = 0;
    done1 = 0; done2 = 0;
    while (!(done1 != 0 && done2 != 0) && cyc < 25000) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (cyc == 1) chk("first_plot", {p1, c1, x1, y1}, {1'b1, 3'd0, 8'd0, 7'd0});
      if (cyc == 2) chk("second_plot", {p1, c1, x1, y1}, {1'b1, 3'd0, 8'd0, 7'd1});
      if (cyc == 19200) chk("last_clear", {p1, c1, x1, y1}, {1'b1, 3'd0, 8'd159, 7'd119});
      if (cyc == 19201) chk("init_noplot", p1, 0);
      if (cyc >= 19202 && cyc <= 19209)
        chk($sformatf("oct%0d", cyc - 19202), {p1, c1, x1, y1},
            {1'b1, 3'b010, 8'(exp_ox[cyc - 19202]), 7'(exp_oy[cyc - 19202])});
      if (cyc == 19204) chk("clip_plot", p2, 0);
      if (cyc == 19204) chk("clip_trunc_x", x2, 221);
      if (cyc <= 19200) begin
        if (p1 && c1 == 3'd0 && x1 < 160 && y1 < 120) begin
          clr_cnt++;
          if (!seen_clr[x1][y1]) clr_uniq++;
          seen_clr[x1][y1] = 1'b1;
        end else clr_other++;
      end else begin
        if (p1) begin
          grn_cnt++;
          dx = int'(x1) - 80;
          dy = int'(y1) - 60;
          d = dx * dx + dy * dy - 1600;
          if (d > 80 || d < -80 || c1 != 3'b010) ring_bad++;
          if (x1 < 160 && y1 < 120) seen_grn[x1][y1] = 1'b1;
        end
        if (p2) begin
          grn2_cnt++;
          if (x2 > 159 || y2 > 119) clip2_bad++;
        end
      end
      if (done1 == 0 && ledr1[0]) done1 = cyc;
      if (done2 == 0 && ledr2[0]) done2 = cyc;
    end
    chk("clear_count", clr_cnt, 19200);
    chk("clear_unique", clr_uniq, 19200);
    chk("clear_other", clr_other, 0);
    chk("done_cycle", done1, 19462);
    chk("done_cycle_clipped", done2, 19462);
    chk("done_led", ledr1, 10'd1);
    chk("done_noplot", p1, 0);
    chk("green_count", grn_cnt, 232);
    chk("ring_error", ring_bad, 0);
    sym_ok = 0;
    for (int i = 0; i < 8; i++) if (seen_grn[sym_x[i]][sym_y[i]]) sym_ok++;
    chk("symmetry", sym_ok, 8);
    chk("clip_range", clip2_bad, 0);
    chk("clip_fewer", (grn2_cnt < 232 && grn2_cnt > 0), 1);

    key[3] = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    key[3] = 1'b0;
    repeat (19205) @(posedge clk);
    @(negedge clk);
    chk("pre_abort_plot", {p1, x1, y1}, {1'b1, 8'd80, 7'd100});
    #2;
    key[3] = 1'b1;
    #1;
    chk("async_plot", p1, 0);
    chk("async_xy", {x1, y1}, 0);
    chk("async_colour_led", {c1, ledr1}, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    key[3] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("restart_first", {p1, c1, x1, y1}, {1'b1, 3'd0, 8'd0, 7'd0});
    @(posedge clk);
    @(negedge clk);
    chk("restart_second", {p1, c1, x1, y1}, {1'b1, 3'd0, 8'd0, 7'd1});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
